vram_scan_writer: RTL and testbench

Frame-sweep master for the VRAM write path in the clk25M domain. On each rising edge of the 60 Hz frame request it sweeps every pixel of the 640x480 frame in raster order, driving pixel coordinates, linear address and write strobe to the sprite renderer (game FSM). It then collects the renderer's delayed address/strobe/colour return stream and issues the final VRAM port-B write. It is the initiating end of the `whpos`/`wvpos`/`write_vramA`/`write_ENA` → `write_vramB`/`write_ENB`/`vdin` interface.

---
 rtl/vram_scan_writer.sv | 167 ++++++++++++++++
 tb/tb_vram_scan_writer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_scan_writer.sv
// Frame-sweep master for the VRAM write path: raster-scans every pixel to the
// renderer on each frame request, then forwards the renderer's return stream to VRAM.
module vram_scan_writer #(
    parameter int HACT    = 640,
    parameter int VACT    = 480,
    parameter int RET_LAT = 1
) (
    input  logic        clk25M,
    input  logic        reset,
    input  logic        clk60,
    input  logic        enable,
    output logic [9:0]  whpos,
    output logic [9:0]  wvpos,
    output logic [18:0] write_vramA,
    output logic        write_ENA,
    input  logic [18:0] write_vramB,
    input  logic        write_ENB,
    input  logic [11:0] vdin,
    output logic [18:0] vram_addr,
    output logic        vram_we,
    output logic [11:0] vram_din,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        tick_miss,
    output logic        seq_err
);

    localparam logic [9:0]  H_LAST = 10'(HACT - 1);
    localparam logic [18:0] A_LAST = 19'(HACT * VACT - 1);
    localparam int          CW     = $clog2(RET_LAT + 2);
    localparam logic [CW-1:0] D_LOAD = CW'(RET_LAT);
    localparam logic [CW-1:0] G_LOAD = CW'(RET_LAT + 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

    state_t         state_q, state_d;
    logic           c60_q;
    logic [9:0]     whpos_q, whpos_d;
    logic [9:0]     wvpos_q, wvpos_d;
    logic [18:0]    addr_q, addr_d;
    logic           ena_q, ena_d;
    logic [CW-1:0]  drain_q, drain_d;
    logic [CW-1:0]  grace_q, grace_d;
    logic [18:0]    exp_q, exp_d;
    logic           done_q, done_d;
    logic [15:0]    fcnt_q, fcnt_d;
    logic           miss_q, miss_d;
    logic           err_q, err_d;
    logic           we_q;
    logic [18:0]    vaddr_q;
    logic [11:0]    vdin_q;
    logic           start;
    logic           busy_w;

    always_comb begin
        start   = clk60 & ~c60_q;
        busy_w  = (state_q != IDLE);
        state_d = state_q;
        whpos_d = 10'd0;
        wvpos_d = 10'd0;
        addr_d  = 19'd0;
        ena_d   = 1'b0;
        drain_d = drain_q;
        exp_d   = exp_q;

        if (write_ENB) begin
            exp_d = exp_q + 19'd1;
        end

        case (state_q)
            IDLE: begin
                if (start && enable) begin
                    state_d = SWEEP;
                    exp_d   = 19'd0;
                end
            end
            SWEEP: begin
                // First SWEEP cycle only raises the strobe; counters advance after that.
                if (ena_q && (addr_q == A_LAST)) begin
                    state_d = DRAIN;
                    drain_d = D_LOAD;
                end else begin
                    ena_d = 1'b1;
                    if (ena_q) begin
                        addr_d = addr_q + 19'd1;
                        if (whpos_q == H_LAST) begin
                            wvpos_d = wvpos_q + 10'd1;
                        end else begin
                            whpos_d = whpos_q + 10'd1;
                            wvpos_d = wvpos_q;
                        end
                    end
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        grace_d = (grace_q != '0) ? grace_q - CW'(1) : grace_q;
        done_d  = (state_d == DRAIN) && (drain_d == '0);
        fcnt_d  = fcnt_q + 16'(done_d);
        miss_d  = miss_q | (start & busy_w);
        // Returns straggling in right after reset belong to an abandoned sweep.
        err_d   = err_q | (write_ENB && (grace_q == '0) &&
                           ((state_q == IDLE) || (write_vramB != exp_q)));
    end

    always_ff @(posedge clk25M) begin
        if (reset) begin
            state_q <= IDLE;
            c60_q   <= 1'b0;
            whpos_q <= 10'd0;
            wvpos_q <= 10'd0;
            addr_q  <= 19'd0;
            ena_q   <= 1'b0;
            drain_q <= '0;
            grace_q <= G_LOAD;
            exp_q   <= 19'd0;
            done_q  <= 1'b0;
            fcnt_q  <= 16'd0;
            miss_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c60_q   <= clk60;
            whpos_q <= whpos_d;
            wvpos_q <= wvpos_d;
            addr_q  <= addr_d;
            ena_q   <= ena_d;
            drain_q <= drain_d;
            grace_q <= grace_d;
            exp_q   <= exp_d;
            done_q  <= done_d;
            fcnt_q  <= fcnt_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
        end
    end

    // Return path keeps forwarding through reset so in-flight writes still land.
    always_ff @(posedge clk25M) begin
        we_q    <= write_ENB;
        vaddr_q <= write_vramB;
        vdin_q  <= vdin;
    end

    assign whpos       = whpos_q;
    assign wvpos       = wvpos_q;
    assign write_vramA = addr_q;
    assign write_ENA   = ena_q;
    assign vram_we     = we_q;
    assign vram_addr   = vaddr_q;
    assign vram_din    = vdin_q;
    assign busy        = busy_w;
    assign frame_done  = done_q;
    assign frame_cnt   = fcnt_q;
    assign tick_miss   = miss_q;
    assign seq_err     = err_q;

endmodule

// File: tb/tb_vram_scan_writer.sv
// Bench for vram_scan_writer on a reduced 16x8 frame with a one-cycle renderer
// loopback; directed vector table plus hand sequences for frame-level corners.
module tb_vram_scan_writer;

    localparam int HACT = 16;
    localparam int VACT = 8;
    localparam int NPIX = HACT * VACT;

    logic        clk25M = 1'b0;
    logic        reset = 1'b1;
    logic        clk60 = 1'b0;
    logic        enable = 1'b1;
    logic [9:0]  whpos, wvpos;
    logic [18:0] write_vramA;
    logic        write_ENA;
    logic [18:0] write_vramB = 19'd0;
    logic        write_ENB = 1'b0;
    logic [11:0] vdin = 12'd0;
    logic [18:0] vram_addr;
    logic        vram_we;
    logic [11:0] vram_din;
    logic        busy, frame_done, tick_miss, seq_err;
    logic [15:0] frame_cnt;

    logic        drop_en = 1'b0;
    logic [18:0] drop_addr = 19'd100;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int we_cnt = 0;
    int mon_exp = 0;
    int mon_bad = 0;
    int t_err = -1;
    int t_101 = -1;

    vram_scan_writer #(.HACT(HACT), .VACT(VACT), .RET_LAT(1)) dut (
        .clk25M(clk25M), .reset(reset), .clk60(clk60), .enable(enable),
        .whpos(whpos), .wvpos(wvpos), .write_vramA(write_vramA), .write_ENA(write_ENA),
        .write_vramB(write_vramB), .write_ENB(write_ENB), .vdin(vdin),
        .vram_addr(vram_addr), .vram_we(vram_we), .vram_din(vram_din),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .tick_miss(tick_miss), .seq_err(seq_err)
    );

    always #20 clk25M = ~clk25M;

    // Renderer stand-in: one-cycle return, colour derived from the address.
    always @(posedge clk25M) begin
        write_ENB   <= write_ENA && !(drop_en && write_vramA == drop_addr);
        write_vramB <= write_vramA;
        vdin        <= write_vramA[11:0] ^ 12'h5A5;
    end

    always @(negedge clk25M) begin
        cyc = cyc + 1;
        if (vram_we) begin
            if (drop_en && mon_exp == int'(drop_addr)) mon_exp = mon_exp + 1;
            if (int'(vram_addr) != mon_exp || vram_din != (vram_addr[11:0] ^ 12'h5A5))
                mon_bad = mon_bad + 1;
            mon_exp = mon_exp + 1;
            we_cnt  = we_cnt + 1;
        end
        if (t_err < 0 && seq_err) t_err = cyc;
        if (t_101 < 0 && write_ENB && write_vramB == 19'd101) t_101 = cyc;
    end

    typedef struct {
        int cyc;
        int ena;
        int hp;
        int vp;
        int addr;
        int bsy;
        int done;
        int fc;
        int we;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic mon_reset();
        we_cnt = 0; mon_exp = 0; mon_bad = 0; t_err = -1; t_101 = -1;
    endtask

    // Returns at the negedge just after the start edge.
    task automatic start_sweep();
        @(negedge clk25M) clk60 = 1'b1;
        @(negedge clk25M) clk60 = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk25M);
            if (frame_done) ok = 1'b1;
        end
        chk({nm, ".done_seen"}, 32'(ok), 32'd1);
    endtask

    initial begin
        vecs[0] = '{0,   0, 0,  0, 0,   1, 0, 0, 0};
        vecs[1] = '{1,   1, 0,  0, 0,   1, 0, 0, 0};
        vecs[2] = '{2,   1, 1,  0, 1,   1, 0, 0, 0};
        vecs[3] = '{16,  1, 15, 0, 15,  1, 0, 0, 1};
        vecs[4] = '{17,  1, 0,  1, 16,  1, 0, 0, 1};
        vecs[5] = '{40,  1, 7,  2, 39,  1, 0, 0, 1};
        vecs[6] = '{128, 1, 15, 7, 127, 1, 0, 0, 1};
        vecs[7] = '{129, 0, 0,  0, 0,   1, 0, 0, 1};
        vecs[8] = '{130, 0, 0,  0, 0,   1, 1, 1, 1};
        vecs[9] = '{131, 0, 0,  0, 0,   0, 0, 1, 0};

        repeat (3) @(negedge clk25M);
        reset = 1'b0;
        @(negedge clk25M);
        chk("rst.ena", 32'(write_ENA), 0);
        chk("rst.addr", 32'(write_vramA), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.fcnt", 32'(frame_cnt), 0);
        chk("rst.flags", {30'd0, tick_miss, seq_err}, 0);
        chk("rst.we", 32'(vram_we), 0);

        // Frame 1: table of probe points relative to the start edge.
        mon_reset();
        start_sweep();
        begin
            int cur;
            cur = 0;
            for (int i = 0; i < 10; i++) begin
                while (cur < vecs[i].cyc) begin
                    @(negedge clk25M);
                    cur++;
                end
                chk($sformatf("vec%0d.ena", i), 32'(write_ENA), vecs[i].ena);
                chk($sformatf("vec%0d.hpos", i), 32'(whpos), vecs[i].hp);
                chk($sformatf("vec%0d.vpos", i), 32'(wvpos), vecs[i].vp);
                chk($sformatf("vec%0d.addr", i), 32'(write_vramA), vecs[i].addr);
                chk($sformatf("vec%0d.busy", i), 32'(busy), vecs[i].bsy);
                chk($sformatf("vec%0d.done", i), 32'(frame_done), vecs[i].done);
                chk($sformatf("vec%0d.fcnt", i), 32'(frame_cnt), vecs[i].fc);
                chk($sformatf("vec%0d.we", i), 32'(vram_we), vecs[i].we);
                if (vecs[i].done == 1) chk("f1.last_vaddr", 32'(vram_addr), NPIX - 1);
            end
        end
        chk("f1.we_cnt", we_cnt, NPIX);
        chk("f1.order", mon_bad, 0);
        chk("f1.seq_err", 32'(seq_err), 0);

        // Frame 2: second request mid-sweep is dropped and flagged.
        mon_reset();
        start_sweep();
        repeat (40) @(negedge clk25M);
        start_sweep();
        wait_done("f2");
        chk("f2.last_vaddr", 32'(vram_addr), NPIX - 1);
        @(negedge clk25M);
        repeat (5) @(negedge clk25M);
        chk("f2.no_restart", 32'(busy), 0);
        chk("f2.tick_miss", 32'(tick_miss), 1);
        chk("f2.we_cnt", we_cnt, NPIX);
        chk("f2.order", mon_bad, 0);
        chk("f2.fcnt", 32'(frame_cnt), 2);

        // Frame 3: renderer drops the return for address 100.
        mon_reset();
        drop_en = 1'b1;
        start_sweep();
        wait_done("f3");
        @(negedge clk25M);
        chk("f3.seq_err", 32'(seq_err), 1);
        chk("f3.err_lag", t_err - t_101, 1);
        chk("f3.we_cnt", we_cnt, NPIX - 1);
        chk("f3.order", mon_bad, 0);
        drop_en = 1'b0;

        // Request with enable low is ignored; enable falling mid-sweep is not.
        enable = 1'b0;
        begin
            int saw;
            saw = 0;
            start_sweep();
            repeat (10) begin
                @(negedge clk25M);
                if (write_ENA || busy) saw++;
            end
            chk("en0.no_sweep", saw, 0);
        end
        enable = 1'b1;
        mon_reset();
        start_sweep();
        repeat (20) @(negedge clk25M);
        enable = 1'b0;
        wait_done("f4");
        @(negedge clk25M);
        chk("f4.we_cnt", we_cnt, NPIX);
        chk("f4.fcnt", 32'(frame_cnt), 4);
        enable = 1'b1;

        // Reset at pixel 50 abandons the sweep; the in-flight return is forwarded quietly.
        start_sweep();
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 200 && !hit; i++) begin
                @(negedge clk25M);
                if (write_vramA == 19'd50 && write_ENA) hit = 1'b1;
            end
            chk("rst50.reach", 32'(hit), 1);
        end
        reset = 1'b1;
        @(negedge clk25M);
        reset = 1'b0;
        chk("rst50.ena", 32'(write_ENA), 0);
        chk("rst50.busy", 32'(busy), 0);
        chk("rst50.fcnt", 32'(frame_cnt), 0);
        @(negedge clk25M);
        chk("rst50.fwd_we", 32'(vram_we), 1);
        chk("rst50.fwd_addr", 32'(vram_addr), 50);
        @(negedge clk25M);
        chk("rst50.seq_err", 32'(seq_err), 0);
        mon_reset();
        start_sweep();
        @(negedge clk25M);
        chk("rst50.restart_ena", 32'(write_ENA), 1);
        chk("rst50.restart_addr", 32'(write_vramA), 0);
        wait_done("f5");
        @(negedge clk25M);
        chk("f5.busy_idle", 32'(busy), 0);
        chk("f5.we_cnt", we_cnt, NPIX);
        chk("f5.order", mon_bad, 0);
        chk("f5.seq_err", 32'(seq_err), 0);
        chk("f5.fcnt", 32'(frame_cnt), 1);

        // Request in the first IDLE cycle is accepted.
        mon_reset();
        clk60 = 1'b1;
        @(negedge clk25M);
        chk("early.busy", 32'(busy), 1);
        chk("early.tick_miss", 32'(tick_miss), 0);
        clk60 = 1'b0;
        wait_done("f6");
        // Request on the DRAIN->IDLE cycle still counts as busy.
        clk60 = 1'b1;
        @(negedge clk25M);
        chk("late.busy", 32'(busy), 0);
        chk("late.tick_miss", 32'(tick_miss), 1);
        chk("f6.fcnt", 32'(frame_cnt), 2);
        clk60 = 1'b0;
        repeat (3) @(negedge clk25M);
        chk("late.no_sweep", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
